// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory (slave).
// Request fields are registered by the master; ack is a one-cycle pulse with rdata.
interface mem_access_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: runs the multi-cycle data-memory handshake, stalls the
// upstream pipeline while an access is outstanding, resolves branches and drives MEM/WB.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      RegWrite_in,
   input  logic                      MemRead_in,
   input  logic                      MemtoReg_in,
   input  logic                      MemWrite_in,
   input  logic                      Branch_in,
   input  logic [31:0]               ALU_OUT_in,
   input  logic                      ZERO_in,
   input  logic [31:0]               PC_Branch_in,
   input  logic [31:0]               REG_DATA2_in,
   input  logic [4:0]                rd_in,
   mem_access_ctrl_if.master         bus,
   output logic                      stall,
   output logic                      PCSrc,
   output logic [31:0]               PC_Branch_out,
   output logic                      RegWrite_out,
   output logic                      MemtoReg_out,
   output logic [31:0]               READ_DATA_out,
   output logic [31:0]               ALU_OUT_out,
   output logic [4:0]                rd_out,
   output logic                      bus_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;

   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] cap_q, cap_d;
   logic        err_q, err_d;
   logic        bus_err_q, bus_err_d;
   logic        reg_write_q, reg_write_d;
   logic        mem_to_reg_q, mem_to_reg_d;
   logic [31:0] read_data_q, read_data_d;
   logic [31:0] alu_out_q, alu_out_d;
   logic [4:0]  rd_q, rd_d;

   logic acc;
   logic aligned;
   logic timeout_hit;

   assign acc         = MemRead_in | MemWrite_in;
   assign aligned     = (ALU_OUT_in[1:0] == 2'b00);
   // An ack sampled in the final BUSY cycle takes priority over the timeout.
   assign timeout_hit = !bus.mem_ack && (cnt_q == TMO_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (acc && aligned) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (bus.mem_ack || timeout_hit) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      stall        = 1'b0;
      PCSrc        = Branch_in & ZERO_in & (state_q == S_IDLE);
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      cap_d        = cap_q;
      err_d        = err_q;
      bus_err_d    = 1'b0;
      reg_write_d  = RegWrite_in;
      mem_to_reg_d = MemtoReg_in;
      alu_out_d    = ALU_OUT_in;
      rd_d         = rd_in;
      read_data_d  = 32'h0000_0000;
      case (state_q)
         S_IDLE: begin
            if (acc) begin
               reg_write_d = 1'b0;
               if (aligned) begin
                  stall   = 1'b1;
                  req_d   = 1'b1;
                  we_d    = MemWrite_in;
                  addr_d  = ALU_OUT_in;
                  wdata_d = REG_DATA2_in;
                  cnt_d   = 8'd0;
                  err_d   = 1'b0;
               end else begin
                  bus_err_d = 1'b1;
               end
            end
         end
         S_BUSY: begin
            stall       = 1'b1;
            reg_write_d = 1'b0;
            if (bus.mem_ack) begin
               cap_d = bus.mem_rdata;
               req_d = 1'b0;
            end else if (timeout_hit) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               cap_d     = ERR_RDATA;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            // EX/MEM still holds the completed access; this edge retires it.
            read_data_d = cap_q;
            if (err_q) begin
               reg_write_d = 1'b0;
            end
         end
         default: begin
            reg_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0000_0000;
         wdata_q      <= 32'h0000_0000;
         cnt_q        <= 8'd0;
         cap_q        <= 32'h0000_0000;
         err_q        <= 1'b0;
         bus_err_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         read_data_q  <= 32'h0000_0000;
         alu_out_q    <= 32'h0000_0000;
         rd_q         <= 5'd0;
      end else begin
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         cap_q        <= cap_d;
         err_q        <= err_d;
         bus_err_q    <= bus_err_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         read_data_q  <= read_data_d;
         alu_out_q    <= alu_out_d;
         rd_q         <= rd_d;
      end
   end

   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   assign PC_Branch_out = PC_Branch_in;
   assign RegWrite_out  = reg_write_q;
   assign MemtoReg_out  = mem_to_reg_q;
   assign READ_DATA_out = read_data_q;
   assign ALU_OUT_out   = alu_out_q;
   assign rd_out        = rd_q;
   assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: acts as pipeline and memory, predicts each access at
// transaction level (occupancy, request cycles, error, final MEM/WB contents).
module tb_mem_access_ctrl;
   localparam int          TMO     = 4;
   localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite_in, MemRead_in, MemtoReg_in, MemWrite_in, Branch_in, ZERO_in;
   logic [31:0] ALU_OUT_in, PC_Branch_in, REG_DATA2_in;
   logic [4:0]  rd_in;
   logic        stall, PCSrc, RegWrite_out, MemtoReg_out, bus_err;
   logic [31:0] PC_Branch_out, READ_DATA_out, ALU_OUT_out;
   logic [4:0]  rd_out;

   int checks = 0;
   int errors = 0;

   mem_access_ctrl_if bus_if ();

   mem_access_ctrl #(
      .TIMEOUT   (TMO),
      .ERR_RDATA (ERR_VAL)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .RegWrite_in   (RegWrite_in),
      .MemRead_in    (MemRead_in),
      .MemtoReg_in   (MemtoReg_in),
      .MemWrite_in   (MemWrite_in),
      .Branch_in     (Branch_in),
      .ALU_OUT_in    (ALU_OUT_in),
      .ZERO_in       (ZERO_in),
      .PC_Branch_in  (PC_Branch_in),
      .REG_DATA2_in  (REG_DATA2_in),
      .rd_in         (rd_in),
      .bus           (bus_if),
      .stall         (stall),
      .PCSrc         (PCSrc),
      .PC_Branch_out (PC_Branch_out),
      .RegWrite_out  (RegWrite_out),
      .MemtoReg_out  (MemtoReg_out),
      .READ_DATA_out (READ_DATA_out),
      .ALU_OUT_out   (ALU_OUT_out),
      .rd_out        (rd_out),
      .bus_err       (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_idle();
      RegWrite_in  = 1'b0;
      MemRead_in   = 1'b0;
      MemtoReg_in  = 1'b0;
      MemWrite_in  = 1'b0;
      Branch_in    = 1'b0;
      ZERO_in      = 1'b0;
      ALU_OUT_in   = 32'h0;
      PC_Branch_in = 32'h0;
      REG_DATA2_in = 32'h0;
      rd_in        = 5'd0;
   endtask

   task automatic check_regs_zero(input string tag);
      check({tag, "_req"},   32'(bus_if.mem_req), 32'h0);
      check({tag, "_we"},    32'(bus_if.mem_we), 32'h0);
      check({tag, "_addr"},  bus_if.mem_addr, 32'h0);
      check({tag, "_wdata"}, bus_if.mem_wdata, 32'h0);
      check({tag, "_rw"},    32'(RegWrite_out), 32'h0);
      check({tag, "_m2r"},   32'(MemtoReg_out), 32'h0);
      check({tag, "_rdata"}, READ_DATA_out, 32'h0);
      check({tag, "_alu"},   ALU_OUT_out, 32'h0);
      check({tag, "_rd"},    32'(rd_out), 32'h0);
      check({tag, "_err"},   32'(bus_err), 32'h0);
   endtask

   // One EX/MEM instruction, held until the controller lets it advance.
   // k = BUSY cycle (1-based) in which the memory acks; k > TMO means no ack.
   task automatic run_op(input logic rw, input logic mr, input logic m2r, input logic mw,
                         input logic br, input logic z, input logic [31:0] addr,
                         input logic [31:0] pcb, input logic [31:0] wdata, input logic [4:0] rd,
                         input int k, input logic [31:0] ack_val);
      bit          acc     = mr | mw;
      bit          al      = (addr[1:0] == 2'b00);
      bit          go      = acc && al;
      bit          exp_to  = go && (k > TMO);
      int          exp_bsy = go ? ((k > TMO) ? TMO : k) : 0;
      bit          exp_err = (acc && !al) || exp_to;
      logic [31:0] ack_data = 32'h0;
      logic [31:0] exp_rdata;
      logic        exp_rw;
      int          n_stall = 0;
      int          n_req   = 0;
      int          n_err   = 0;
      bit          done    = 0;

      RegWrite_in  = rw;
      MemRead_in   = mr;
      MemtoReg_in  = m2r;
      MemWrite_in  = mw;
      Branch_in    = br;
      ZERO_in      = z;
      ALU_OUT_in   = addr;
      PC_Branch_in = pcb;
      REG_DATA2_in = wdata;
      rd_in        = rd;

      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         #1;
         check("pcsrc", 32'(PCSrc), 32'((cyc == 0) && br && z));
         check("pc_branch_out", PC_Branch_out, pcb);
         if (cyc > 0) begin
            n_err += int'(bus_err);
            check("bubble_rw", 32'(RegWrite_out), 32'h0);
         end
         if (stall) n_stall++;
         else done = 1;
         if (bus_if.mem_req) begin
            n_req++;
            check("mem_addr", bus_if.mem_addr, addr);
            check("mem_we", 32'(bus_if.mem_we), 32'(mw));
            check("mem_wdata", bus_if.mem_wdata, wdata);
            if (n_req == k) begin
               bus_if.mem_ack   = 1'b1;
               bus_if.mem_rdata = ack_val;
               ack_data         = ack_val;
            end
         end else if ($urandom_range(3) == 0) begin
            // Stray acks in IDLE/DONE must have no effect.
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = $urandom;
         end
         @(posedge clk);
         @(negedge clk);
         bus_if.mem_ack = 1'b0;
      end
      if (!done) check("op_timeout", 32'h0, 32'h1);

      #1;
      n_err += int'(bus_err);
      exp_rdata = go ? (exp_to ? ERR_VAL : ack_data) : 32'h0;
      exp_rw    = go ? (rw & ~exp_to) : (acc ? 1'b0 : rw);
      check("stall_cycles", 32'(n_stall), 32'(go ? exp_bsy + 1 : 0));
      check("req_cycles", 32'(n_req), 32'(exp_bsy));
      check("bus_err_pulses", 32'(n_err), 32'(exp_err));
      check("wb_regwrite", 32'(RegWrite_out), 32'(exp_rw));
      check("wb_memtoreg", 32'(MemtoReg_out), 32'(m2r));
      check("wb_alu", ALU_OUT_out, addr);
      check("wb_rd", 32'(rd_out), 32'(rd));
      check("wb_rdata", READ_DATA_out, exp_rdata);
      $display("op rw=%0b mr=%0b mw=%0b addr=%h k=%0d stalls=%0d reqs=%0d err=%0d rdata=%h",
               rw, mr, mw, addr, k, n_stall, n_req, n_err, READ_DATA_out);
   endtask

   initial begin
      logic [31:0] a;
      reset            = 1'b1;
      bus_if.mem_ack   = 1'b0;
      bus_if.mem_rdata = 32'h0;
      drive_idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_regs_zero("reset");
      check("reset_stall", 32'(stall), 32'h0);
      reset = 1'b0;

      // Directed cases
      run_op(1, 0, 0, 0, 0, 0, 32'h1234, 32'h40, 32'h0, 5'd5, 0, 32'h0);
      run_op(1, 1, 1, 0, 0, 0, 32'h100, 32'h44, 32'h0, 5'd7, 2, 32'hCAFE_F00D);
      run_op(0, 0, 0, 1, 0, 0, 32'h204, 32'h48, 32'hA5A5_A5A5, 5'd0, 1, 32'h1111_2222);
      run_op(1, 1, 1, 0, 0, 0, 32'h102, 32'h4C, 32'h0, 5'd3, 1, 32'h0);
      run_op(1, 1, 1, 0, 0, 0, 32'h300, 32'h50, 32'h0, 5'd9, 99, 32'h0);
      run_op(0, 0, 0, 0, 1, 1, 32'h0, 32'h800, 32'h0, 5'd0, 0, 32'h0);
      run_op(1, 1, 1, 0, 1, 1, 32'h104, 32'h900, 32'h0, 5'd4, 3, 32'h5555_AAAA);
      run_op(1, 1, 1, 1, 0, 0, 32'h108, 32'h0, 32'h7777_8888, 5'd6, TMO, 32'h1357_9BDF);

      // Randomised instruction stream
      for (int n = 0; n < 150; n++) begin
         a = $urandom;
         if ($urandom_range(3) != 0) a[1:0] = 2'b00;
         run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(2) == 0),
                1'($urandom), 1'($urandom), a, $urandom, $urandom, 5'($urandom),
                $urandom_range(1, TMO + 2), $urandom);
      end

      // Reset in the middle of an access
      RegWrite_in  = 1'b1;
      MemRead_in   = 1'b1;
      MemWrite_in  = 1'b0;
      ALU_OUT_in   = 32'h400;
      rd_in        = 5'd2;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("pre_reset_req", 32'(bus_if.mem_req), 32'h1);
      drive_idle();
      Branch_in = 1'b1;
      ZERO_in   = 1'b1;
      reset     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check_regs_zero("mid_reset");
      check("mid_reset_pcsrc", 32'(PCSrc), 32'h1);
      check("mid_reset_stall", 32'(stall), 32'h0);
      reset            = 1'b0;
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'hBAD0_BAD0;
      @(posedge clk);
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      #1;
      check("late_ack_req", 32'(bus_if.mem_req), 32'h0);
      check("late_ack_rdata", READ_DATA_out, 32'h0);
      check("late_ack_err", 32'(bus_err), 32'h0);
      run_op(1, 1, 1, 0, 0, 0, 32'h500, 32'h0, 32'h0, 5'd8, 1, 32'h0BAD_F00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage controller between the EX/MEM pipeline register outputs and a multi-cycle data-memory bus. It consumes the EX/MEM register's control and data fields.
- Runs the memory request/acknowledge handshake and produces a stall that is fed back to the pipeline-register write enables.
- Resolves branches (PCSrc) and drives registered MEM/WB fields.

Parameters:
- TIMEOUT, 16, max BUSY cycles waiting for mem_ack before a bus error (range 2..255).
- ERR_RDATA, 32'h0000_0000, read data delivered on a timed-out load.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- RegWrite_in, MemRead_in, MemtoReg_in, MemWrite_in, Branch_in  in  1 each  control fields from EX/MEM.
- ALU_OUT_in  in  32  memory address / ALU result.
- ZERO_in  in  1  ALU zero flag.
- PC_Branch_in  in  32  branch target.
- REG_DATA2_in  in  32  store data.
- rd_in  in  5  destination register.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  word address, registered.
- mem_wdata  out  32  store data, registered.
- mem_ack  in  1  bus acknowledge, single-cycle pulse.
- mem_rdata  in  32  read data, valid with mem_ack.
- stall  out  1  combinational; 1 = hold PC/IF/ID/ID/EX/EX/MEM (drive their write enable low).
- PCSrc  out  1  combinational; take branch.
- PC_Branch_out  out  32  equals PC_Branch_in.
- RegWrite_out, MemtoReg_out  out  1 each  MEM/WB controls, registered.
- READ_DATA_out  out  32  MEM/WB load data, registered.
- ALU_OUT_out  out  32  MEM/WB ALU result, registered.
- rd_out  out  5  MEM/WB rd, registered.
- bus_err  out  1  one-cycle pulse on misaligned access or timeout.

Behaviour:
- Reset: every registered output is 0 and state is IDLE. Any in-flight request is abandoned (mem_req 0 after the reset edge). An ack arriving after reset is ignored.
- Access condition: `acc = MemRead_in | MemWrite_in`. If both are set, the access is a write.
- Alignment: `aligned = (ALU_OUT_in[1:0] == 2'b00)`.
- States: IDLE, BUSY, DONE.
- IDLE, no acc:
  - stall = 0.
  - At the edge, MEM/WB outputs load from the inputs; READ_DATA_out = 0.
  - 1-cycle latency.
- IDLE, acc, misaligned:
  - stall = 0, no request.
  - At the edge, bus_err = 1 for one cycle and RegWrite_out = 0 (bubble).
  - Other MEM/WB fields load normally. Stay in IDLE.
- IDLE, acc, aligned:
  - stall = 1.
  - At the edge: go BUSY; mem_req = 1; mem_we = MemWrite_in; mem_addr = ALU_OUT_in; mem_wdata = REG_DATA2_in; timeout counter = 0.
  - MEM/WB gets a bubble (RegWrite_out = 0).
- BUSY:
  - stall = 1; MEM/WB gets a bubble each edge.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until an ack is sampled.
  - On mem_ack: capture mem_rdata, mem_req = 0, go DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack: mem_req = 0, bus_err pulse, captured data = ERR_RDATA, error flag set, go DONE.
- DONE:
  - stall = 0, so EX/MEM advances at this edge.
  - Inputs still describe the completed access and must not retrigger.
  - At the edge, MEM/WB loads from the inputs with READ_DATA_out = captured data. RegWrite_out is forced 0 if the error flag is set. Go IDLE.
- PCSrc = Branch_in & ZERO_in & (state == IDLE). PC_Branch_out passes PC_Branch_in straight through.
- Ack timing: an ack in IDLE or DONE is ignored. An ack in the same cycle the timeout fires wins, and no error is raised.
- Back-to-back accesses: DONE → IDLE → the next access starts, so there is a minimum 3-cycle occupancy per access with zero-wait memory (ack in the first BUSY cycle).

Test Plan:
1. ALU op (RegWrite_in=1, ALU_OUT_in=32'h1234, rd_in=5, no mem) → next cycle RegWrite_out=1, ALU_OUT_out=32'h1234, rd_out=5; stall never 1.
2. Load at 32'h100, ack after 2 BUSY cycles with rdata 32'hCAFEF00D:
   - mem_req high exactly 2 cycles, mem_we=0, mem_addr=32'h100;
   - stall high for 3 cycles;
   - after DONE, READ_DATA_out=32'hCAFEF00D and MemtoReg_out=1.
3. Store at 32'h204 with data 32'hA5A5A5A5, ack in the first BUSY cycle → mem_we=1, mem_wdata=32'hA5A5A5A5; stall for 2 cycles; RegWrite_out=0.
4. Misaligned load at 32'h102 → mem_req never asserts, bus_err pulses 1 cycle, RegWrite_out=0, stall=0.
5. TIMEOUT=4, no ack → bus_err pulses after 4 BUSY cycles, READ_DATA_out=ERR_RDATA, RegWrite_out=0; a late ack in IDLE is ignored.
6. Reset asserted in BUSY → next cycle mem_req=0, state IDLE, all outputs 0. Separately: Branch_in=1, ZERO_in=1 in IDLE → PCSrc=1; the same inputs during BUSY → PCSrc=0.
